// File: rtl/alu_driver.sv
// Sequential front-end that loads A, B and opcode into the ALU via push-button steps, then captures res and flags.
// Latency: result_valid is visible two cycles after the opcode-step pulse, plus SYNC_STAGES+DB_CYCLES cycles of button filtering.
// Backpressure: none; a step pulse arriving while in S_EXEC is dropped, and the clear button overrides the step button.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   sw_data, sw_code        switch values captured as operand A/B and as the opcode
//   btn_next, btn_clr       raw asynchronous push-buttons: advance the sequence / abort it
//   alu_opa/opb/code        registered operands and opcode driven into the external ALU
//   alu_res                 combinational ALU result
//   result, result_valid    captured result and its valid flag
//   carry, borrow, zero     unsigned status flags for the captured result
//   state_led               current FSM state encoding
module alu_driver #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_data,
    input  logic [2:0]   sw_code,
    input  logic         btn_next,
    input  logic         btn_clr,
    output logic [W-1:0] alu_opa,
    output logic [W-1:0] alu_opb,
    output logic [2:0]   alu_code,
    input  logic [W-1:0] alu_res,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         carry,
    output logic         borrow,
    output logic         zero,
    output logic [2:0]   state_led
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Bit 0 is the step button, bit 1 the clear button.
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    assign btn_raw = {btn_clr, btn_next};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   db_q;
        logic                   db_d_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                cnt_q  <= '0;
                db_q   <= 1'b0;
                db_d_q <= 1'b0;
            end else begin
                sync_q[0] <= btn_raw[i];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
                db_d_q <= db_q;
                // Any sample agreeing with the debounced level restarts the count,
                // so only DB_CYCLES consecutive differing samples flip the level.
                if (sync_q[SYNC_STAGES-1] != db_q) begin
                    if (cnt_q == CNT_MAX) begin
                        db_q  <= ~db_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        // Press only: a falling debounced level yields nothing.
        assign btn_pulse[i] = db_q & ~db_d_q;
    end

    logic next_pulse;
    logic clr_pulse;
    assign next_pulse = btn_pulse[0];
    assign clr_pulse  = btn_pulse[1];

    state_t state_q, state_d;
    logic   ld_a, ld_b, ld_op, capture, clear_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_a        = 1'b0;
        ld_b        = 1'b0;
        ld_op       = 1'b0;
        capture     = 1'b0;
        clear_flags = 1'b0;
        if (clr_pulse) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:    if (next_pulse) begin ld_a  = 1'b1; state_d = S_B;    end
                S_B:    if (next_pulse) begin ld_b  = 1'b1; state_d = S_OP;   end
                S_OP:   if (next_pulse) begin ld_op = 1'b1; state_d = S_EXEC; end
                S_EXEC: begin capture = 1'b1; state_d = S_SHOW; end
                S_SHOW: if (next_pulse) begin clear_flags = 1'b1; state_d = S_A; end
                default: state_d = S_A;
            endcase
        end
    end

    logic [W-1:0] a_q, b_q, result_q;
    logic [2:0]   op_q;
    logic         valid_q, carry_q, borrow_q, zero_q;
    logic [W:0]   sum;

    // Extra bit catches the unsigned add overflow independently of the ALU.
    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else if (clr_pulse) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            if (ld_a)  a_q  <= sw_data;
            if (ld_b)  b_q  <= sw_data;
            if (ld_op) op_q <= sw_code;
            if (capture) begin
                result_q <= alu_res;
                carry_q  <= (op_q == 3'b000) && sum[W];
                borrow_q <= (op_q == 3'b001) && (a_q < b_q);
                zero_q   <= (alu_res == '0);
                valid_q  <= 1'b1;
            end
            // The result register is kept so the display can still show it.
            if (clear_flags) begin
                valid_q  <= 1'b0;
                carry_q  <= 1'b0;
                borrow_q <= 1'b0;
                zero_q   <= 1'b0;
            end
        end
    end

    assign alu_opa      = a_q;
    assign alu_opb      = b_q;
    assign alu_code     = op_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign carry        = carry_q;
    assign borrow       = borrow_q;
    assign zero         = zero_q;
    assign state_led    = state_q;

endmodule

// File: tb/tb_alu_driver.sv
module tb_alu_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_data = '0;
    logic [2:0] sw_code = '0;
    logic       btn_next = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] alu_opa, alu_opb, alu_res, result;
    logic [2:0] alu_code, state_led;
    logic       result_valid, carry, borrow, zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: 000 add, 001 sub, 010 and, 011 or, 101 xor, 111 equality.
    always_comb begin
        case (alu_code)
            3'b000:  alu_res = alu_opa + alu_opb;
            3'b001:  alu_res = alu_opa - alu_opb;
            3'b010:  alu_res = alu_opa & alu_opb;
            3'b011:  alu_res = alu_opa | alu_opb;
            3'b101:  alu_res = alu_opa ^ alu_opb;
            3'b111:  alu_res = (alu_opa == alu_opb) ? 4'd1 : 4'd0;
            default: alu_res = 4'd0;
        endcase
    end

    alu_driver #(.W(4), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_data(sw_data), .sw_code(sw_code),
        .btn_next(btn_next), .btn_clr(btn_clr),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_code(alu_code),
        .alu_res(alu_res),
        .result(result), .result_valid(result_valid),
        .carry(carry), .borrow(borrow), .zero(zero),
        .state_led(state_led)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d, input logic [2:0] c);
        sw_data  = d;
        sw_code  = c;
        btn_next = 1'b1;
        tick(12);
        btn_next = 1'b0;
        tick(12);
    endtask

    task automatic do_seq(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        press(a, 3'd0);
        press(b, 3'd0);
        press(4'd0, c);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({alu_opa, alu_opb, alu_code, result, result_valid, carry, borrow, zero} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h want 0",
                     {alu_opa, alu_opb, alu_code, result, result_valid, carry, borrow, zero});
        end
        checks++;
        if (state_led !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_led); end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_basic_add();
        int n;
        press(4'd5, 3'd0);
        checks++;
        if (state_led !== 3'd1) begin errors++; $display("FAIL add_state_b: got %0d want 1", state_led); end
        checks++;
        if (alu_opa !== 4'd5) begin errors++; $display("FAIL add_opa: got %0h want 5", alu_opa); end
        press(4'd3, 3'd0);
        checks++;
        if (state_led !== 3'd2) begin errors++; $display("FAIL add_state_op: got %0d want 2", state_led); end
        checks++;
        if (alu_opb !== 4'd3) begin errors++; $display("FAIL add_opb: got %0h want 3", alu_opb); end
        sw_code  = 3'b000;
        btn_next = 1'b1;
        n = 0;
        while (state_led !== 3'd3 && n < 30) begin
            tick(1);
            n++;
        end
        // 2 sync + 4 debounce edges raise the pulse, the 7th edge moves the FSM.
        checks++;
        if (n !== 7) begin errors++; $display("FAIL add_exec_entry_cycles: got %0d want 7", n); end
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL add_valid_early: got %0b want 0", result_valid); end
        tick(1);
        checks++;
        if (state_led !== 3'd4) begin errors++; $display("FAIL add_exec_one_cycle: got %0d want 4", state_led); end
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", result_valid); end
        checks++;
        if ({result, carry, borrow, zero} !== {4'd8, 3'b000}) begin
            errors++;
            $display("FAIL add_result: got %0h want %0h", {result, carry, borrow, zero}, {4'd8, 3'b000});
        end
        btn_next = 1'b0;
        tick(12);
        press(4'd0, 3'd0);
        checks++;
        if ({state_led, result_valid, result} !== {3'd0, 1'b0, 4'd8}) begin
            errors++;
            $display("FAIL add_back_to_a: got %0h want %0h", {state_led, result_valid, result}, {3'd0, 1'b0, 4'd8});
        end
    endtask

    task automatic test_flags();
        do_seq(4'hC, 4'h7, 3'b000);
        checks++;
        if ({state_led, result, carry, borrow, zero, result_valid} !== {3'd4, 4'h3, 4'b1001}) begin
            errors++;
            $display("FAIL carry_case: got %0h want %0h",
                     {state_led, result, carry, borrow, zero, result_valid}, {3'd4, 4'h3, 4'b1001});
        end
        press(4'd0, 3'd0);
        do_seq(4'h2, 4'h5, 3'b001);
        checks++;
        if ({result, carry, borrow, zero, result_valid} !== {4'hD, 4'b0101}) begin
            errors++;
            $display("FAIL borrow_case: got %0h want %0h",
                     {result, carry, borrow, zero, result_valid}, {4'hD, 4'b0101});
        end
        press(4'd0, 3'd0);
    endtask

    task automatic test_logic_ops();
        do_seq(4'h9, 4'h9, 3'b111);
        checks++;
        if ({result, carry, borrow, zero, result_valid} !== {4'h1, 4'b0001}) begin
            errors++;
            $display("FAIL eq_case: got %0h want %0h", {result, carry, borrow, zero, result_valid}, {4'h1, 4'b0001});
        end
        press(4'd0, 3'd0);
        do_seq(4'h6, 4'h6, 3'b101);
        checks++;
        if ({result, carry, borrow, zero, result_valid} !== {4'h0, 4'b0011}) begin
            errors++;
            $display("FAIL zero_case: got %0h want %0h", {result, carry, borrow, zero, result_valid}, {4'h0, 4'b0011});
        end
        press(4'd0, 3'd0);
        checks++;
        if ({state_led, result, carry, borrow, zero, result_valid} !== {3'd0, 4'h0, 4'b0000}) begin
            errors++;
            $display("FAIL show_exit: got %0h want 0", {state_led, result, carry, borrow, zero, result_valid});
        end
    endtask

    task automatic test_glitch();
        sw_data  = 4'hA;
        btn_next = 1'b1;
        tick(3);
        btn_next = 1'b0;
        tick(12);
        checks++;
        if (state_led !== 3'd0) begin errors++; $display("FAIL glitch_ignored: got %0d want 0", state_led); end
        btn_next = 1'b1;
        tick(200);
        checks++;
        if (state_led !== 3'd1) begin errors++; $display("FAIL long_hold_one_step: got %0d want 1", state_led); end
        btn_next = 1'b0;
        tick(20);
        checks++;
        if ({state_led, alu_opa} !== {3'd1, 4'hA}) begin
            errors++;
            $display("FAIL release_no_step: got %0h want %0h", {state_led, alu_opa}, {3'd1, 4'hA});
        end
    endtask

    task automatic test_clr_priority();
        press(4'h6, 3'd0);
        checks++;
        if (state_led !== 3'd2) begin errors++; $display("FAIL clr_setup: got %0d want 2", state_led); end
        sw_code  = 3'd5;
        btn_clr  = 1'b1;
        btn_next = 1'b1;
        tick(20);
        checks++;
        if ({state_led, alu_opa, alu_opb, alu_code, result_valid} !== 15'd0) begin
            errors++;
            $display("FAIL clr_over_next: got %0h want 0", {state_led, alu_opa, alu_opb, alu_code, result_valid});
        end
        btn_clr  = 1'b0;
        btn_next = 1'b0;
        tick(12);
        checks++;
        if (state_led !== 3'd0) begin errors++; $display("FAIL clr_release: got %0d want 0", state_led); end
    endtask

    task automatic test_async_reset();
        int n;
        press(4'hB, 3'd0);
        checks++;
        if ({state_led, alu_opa} !== {3'd1, 4'hB}) begin
            errors++;
            $display("FAIL ar_setup: got %0h want %0h", {state_led, alu_opa}, {3'd1, 4'hB});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state_led, alu_opa, alu_opb, alu_code, result, result_valid, carry, borrow, zero} !== 22'd0) begin
            errors++;
            $display("FAIL ar_immediate: got %0h want 0",
                     {state_led, alu_opa, alu_opb, alu_code, result, result_valid, carry, borrow, zero});
        end
        btn_next = 1'b1;
        tick(5);
        rst_n = 1'b1;
        n = 0;
        while (state_led === 3'd0 && n < 30) begin
            tick(1);
            n++;
        end
        checks++;
        if (n < 6 || n !== 7) begin errors++; $display("FAIL ar_held_button_delay: got %0d want 7", n); end
        btn_next = 1'b0;
        tick(20);
        checks++;
        if ({state_led, alu_opa} !== {3'd1, 4'hB}) begin
            errors++;
            $display("FAIL ar_single_pulse: got %0h want %0h", {state_led, alu_opa}, {3'd1, 4'hB});
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_flags();
        test_logic_ops();
        test_glitch();
        test_clr_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Sequential front-end that drives the team's 4-bit combinational ALU (opa/opb/code in, res out) from board switches and one push-button.
- Collects operand A, operand B and the 3-bit opcode over three button presses, then presents them to the ALU.
- Captures res one cycle later, derives status flags, and holds everything for LED/seven-seg display.
- Sits between the board I/O layer and the ALU instance in the top level.

Parameters:
- W, 4, operand/result width; must match the ALU.
- SYNC_STAGES, 2, flip-flop synchroniser depth on each raw button input.
- DB_CYCLES, 4, consecutive stable cycles required before the debounced button level changes. Benches use 4; the board top overrides it to about 2^20.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- sw_data  input  W  switch value captured as operand A or B
- sw_code  input  3  switch value captured as the opcode
- btn_next  input  1  raw push-button, asynchronous, active-high; advances the FSM
- btn_clr  input  1  raw push-button, asynchronous, active-high; aborts to start
- alu_opa  output  W  registered operand A to ALU
- alu_opb  output  W  registered operand B to ALU
- alu_code  output  3  registered opcode to ALU
- alu_res  input  W  combinational result from ALU
- result  output  W  captured ALU result
- result_valid  output  1  result and flags are valid
- carry  output  1  add overflow (code 000 and A+B > 2^W-1)
- borrow  output  1  subtract underflow (code 001 and A < B, unsigned)
- zero  output  1  result == 0
- state_led  output  3  current FSM state encoding

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - FSM is in S_A.
  - Synchroniser and debounce registers are 0.
  - Debounce counters are 0.
- Button path (per button):
  - SYNC_STAGES-FF synchroniser, then debounce counter.
  - Counter increments while the synced level differs from the debounced level. It resets to 0 when they match.
  - When the count reaches DB_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - Rising-edge detect on the debounced level gives a one-cycle pulse per press.
  - Release produces no pulse. Glitches shorter than DB_CYCLES produce no pulse.
- FSM states (state_led encoding): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - S_A: on next pulse, A<=sw_data, go to S_B.
  - S_B: on next pulse, B<=sw_data, go to S_OP.
  - S_OP: on next pulse, OP<=sw_code, go to S_EXEC.
  - S_EXEC: unconditional, exactly one cycle. At its closing edge:
    - result<=alu_res
    - carry<=(OP==000)&&(A+B)>2^W-1, using a W+1-bit sum
    - borrow<=(OP==001)&&(A<B)
    - zero<=(alu_res==0)
    - result_valid<=1
    - go to S_SHOW.
  - S_SHOW: hold all outputs. On next pulse, clear result_valid/carry/borrow/zero, go to S_A. A, B, OP and result keep their values until overwritten.
- Next pulses in S_EXEC are ignored.
- alu_opa/alu_opb/alu_code are driven continuously from the A/B/OP registers, so the ALU inputs are stable for the whole S_EXEC cycle.
- Latency: next pulse accepted in S_OP at cycle P gives result_valid=1 visible in cycle P+2.
- btn_clr pulse in any state, synchronous:
  - A, B, OP, result and all flags go to 0; state goes to S_A.
  - clr has priority over a simultaneous next pulse.
  - A clr during S_EXEC suppresses the capture.
- Asynchronous reset mid-sequence returns everything to reset values immediately. The debouncers restart, so a button held through reset release produces a pulse only after DB_CYCLES stable cycles.
- Flags are unsigned interpretations only. There is no signed overflow flag.

Test Plan:
- Reset, then A=5, B=3, code=000 via three presses -> S_EXEC lasts 1 cycle; result=8, carry=0, borrow=0, zero=0, result_valid at P+2; state_led 0->1->2->3->4.
- A=4'hC, B=4'h7, code=000 -> result=4'h3, carry=1, zero=0; A=2, B=5, code=001 -> result=4'hD, borrow=1.
- A=9, B=9, code=111 -> result=1. A=6, B=6, code=101 -> result=0, zero=1. Press next in S_SHOW -> S_A, all flags 0, result holds 0.
- Pulse btn_next high for DB_CYCLES-1 cycles (glitch) -> no state change. Hold 2 s -> exactly one advance. Release -> no advance.
- In S_OP, assert btn_clr and btn_next so both debounced edges land on the same cycle -> state S_A, A=B=OP=0, no result_valid.
- Deassert rst_n asynchronously in S_B mid-cycle -> outputs 0 and state_led=0 before the next clk edge. Button held through reset release -> one pulse, no earlier than DB_CYCLES+SYNC_STAGES cycles after release.
